// File: rtl/irq_priority_arbiter_pkg.sv
// Shared types and helpers for the interrupt priority arbiter.
// Holds the acknowledge FSM state encoding and the rotating-rank function.
package irq_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK1 = 1'b1
  } state_t;

  // Rank 0 is the highest priority; the level just above the lowest-priority pointer wins.
  function automatic int rank(input int level, input int lp, input int n);
    return (level - lp - 1 + n) % n;
  endfunction

endpackage

// File: rtl/irq_priority_arbiter_if.sv
// Request/acknowledge/EOI bundle between the controller bus logic and the arbiter.
// master = register/bus side, slave = arbiter.
interface irq_priority_arbiter_if #(
  parameter int N_IRQ = 8
) ();
  localparam int ID_W = $clog2(N_IRQ);

  logic [N_IRQ-1:0] irr;
  logic [N_IRQ-1:0] imr;
  logic             inta;
  logic             eoi_valid;
  logic             eoi_specific;
  logic [ID_W-1:0]  eoi_level;
  logic             eoi_rotate;
  logic             setprio_valid;
  logic             aeoi;
  logic             aeoi_rotate;
  logic             int_req;
  logic [N_IRQ-1:0] isr;
  logic             vec_valid;
  logic [ID_W-1:0]  vec_id;
  logic             spurious;

  modport master (
    output irr, imr, inta, eoi_valid, eoi_specific, eoi_level, eoi_rotate,
           setprio_valid, aeoi, aeoi_rotate,
    input  int_req, isr, vec_valid, vec_id, spurious
  );

  modport slave (
    input  irr, imr, inta, eoi_valid, eoi_specific, eoi_level, eoi_rotate,
           setprio_valid, aeoi, aeoi_rotate,
    output int_req, isr, vec_valid, vec_id, spurious
  );
endinterface

// File: rtl/irq_priority_arbiter_enc.sv
// Rotating priority encoder: returns the lowest-rank set bit of vec relative to
// the lowest-priority pointer lp.
module rot_prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int N_IRQ = 8,
  parameter int ID_W  = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] vec,
  input  logic [ID_W-1:0]  lp,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  logic [ID_W-1:0] rank_of [N_IRQ];

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_rank
      assign rank_of[gi] = ID_W'(rank(gi, int'(lp), N_IRQ));
    end
  endgenerate

  logic [ID_W-1:0] best_rank;

  always_comb begin
    found     = 1'b0;
    idx       = '0;
    best_rank = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (vec[i] && (!found || rank_of[i] < best_rank)) begin
        found     = 1'b1;
        best_rank = rank_of[i];
        idx       = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_priority_arbiter.sv
// Priority resolver, two-pulse INTA sequencer and ISR/EOI tracker.
// Define IRQ_ARB_AEOI_EN to enable automatic EOI on the second INTA.
module irq_priority_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int N_IRQ = 8,
  localparam int ID_W = $clog2(N_IRQ)
) (
  input  logic clk,
  input  logic reset,
  irq_priority_arbiter_if.slave bus
);

  state_t           state_reg, state_next;
  logic [ID_W-1:0]  lp_reg, lp_next;
  logic [N_IRQ-1:0] isr_reg, isr_next, isr_set, isr_clr;
  logic             int_req_reg, int_req_next;
  logic             vec_valid_reg, vec_valid_next;
  logic [ID_W-1:0]  vec_id_reg, vec_id_next;
  logic             spurious_reg, spurious_next;
  logic [ID_W-1:0]  ack_id_reg, ack_id_next;
  logic             spur_pend_reg, spur_pend_next;

  logic             cand_found, nest_found, req_en, lvl_ok;
  logic [ID_W-1:0]  cand_idx, nest_idx;

  rot_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_cand (
    .vec(bus.irr & ~bus.imr), .lp(lp_reg), .found(cand_found), .idx(cand_idx)
  );

  rot_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_nest (
    .vec(isr_reg), .lp(lp_reg), .found(nest_found), .idx(nest_idx)
  );

  // Fully nested: only a strictly higher-priority request may interrupt service.
  assign req_en = cand_found &&
                  (!nest_found ||
                   rank(int'(cand_idx), int'(lp_reg), N_IRQ) < rank(int'(nest_idx), int'(lp_reg), N_IRQ));
  assign lvl_ok = int'(bus.eoi_level) < N_IRQ;

`ifndef IRQ_ARB_AEOI_EN
  logic unused_aeoi;
  assign unused_aeoi = bus.aeoi | bus.aeoi_rotate;
`endif

  always_comb begin
    state_next     = state_reg;
    lp_next        = lp_reg;
    isr_set        = '0;
    isr_clr        = '0;
    int_req_next   = 1'b0;
    vec_valid_next = 1'b0;
    vec_id_next    = vec_id_reg;
    spurious_next  = 1'b0;
    ack_id_next    = ack_id_reg;
    spur_pend_next = spur_pend_reg;

    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        if (lvl_ok) begin
          isr_clr[bus.eoi_level] = 1'b1;
          if (bus.eoi_rotate) lp_next = bus.eoi_level;
        end
      end else if (nest_found) begin
        isr_clr[nest_idx] = 1'b1;
        if (bus.eoi_rotate) lp_next = nest_idx;
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (bus.inta) begin
          state_next = ST_ACK1;
          if (cand_found) begin
            isr_set[cand_idx] = 1'b1;
            ack_id_next       = cand_idx;
            spur_pend_next    = 1'b0;
          end else begin
            ack_id_next    = ID_W'(N_IRQ - 1);
            spur_pend_next = 1'b1;
          end
        end else begin
          int_req_next = req_en;
        end
      end
      ST_ACK1: begin
        if (bus.inta) begin
          state_next     = ST_IDLE;
          vec_valid_next = 1'b1;
          vec_id_next    = ack_id_reg;
          spurious_next  = spur_pend_reg;
`ifdef IRQ_ARB_AEOI_EN
          if (bus.aeoi && !spur_pend_reg) begin
            isr_clr[ack_id_reg] = 1'b1;
            if (bus.aeoi_rotate) lp_next = ack_id_reg;
          end
`endif
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (bus.setprio_valid && lvl_ok) lp_next = bus.eoi_level;

    // A set from the first INTA overrides a same-cycle clear of that bit.
    isr_next = (isr_reg & ~isr_clr) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      lp_reg        <= ID_W'(N_IRQ - 1);
      isr_reg       <= '0;
      int_req_reg   <= 1'b0;
      vec_valid_reg <= 1'b0;
      vec_id_reg    <= '0;
      spurious_reg  <= 1'b0;
      ack_id_reg    <= '0;
      spur_pend_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lp_reg        <= lp_next;
      isr_reg       <= isr_next;
      int_req_reg   <= int_req_next;
      vec_valid_reg <= vec_valid_next;
      vec_id_reg    <= vec_id_next;
      spurious_reg  <= spurious_next;
      ack_id_reg    <= ack_id_next;
      spur_pend_reg <= spur_pend_next;
    end
  end

  assign bus.int_req   = int_req_reg;
  assign bus.isr       = isr_reg;
  assign bus.vec_valid = vec_valid_reg;
  assign bus.vec_id    = vec_id_reg;
  assign bus.spurious  = spurious_reg;

endmodule

// File: doc/irq_priority_arbiter.md
# irq_priority_arbiter

Parametrised priority resolver and in-service tracker for the interrupt controller. It sits between the IRR/IMR registers and the control/data-bus logic:
- Selects the highest-priority unmasked request under fixed or rotating priority.
- Runs the two-pulse INTA acknowledge sequence.
- Maintains the ISR and processes specific, non-specific and automatic EOI.

## Interface
- N_IRQ, 8, number of interrupt levels (2..32).
- ID_W, $clog2(N_IRQ), width of a level index (derived; do not override).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- irr  in  N_IRQ  pending requests, level-held by the IRR block.
- imr  in  N_IRQ  mask bits (1 = masked).
- inta  in  1  single-cycle pulse per bus INTA pulse.
- eoi_valid  in  1  single-cycle EOI command strobe.
- eoi_specific  in  1  1 = specific EOI on eoi_level; 0 = non-specific.
- eoi_level  in  ID_W  target level for specific EOI / set-priority.
- eoi_rotate  in  1  rotate lowest priority to the cleared level with this EOI.
- setprio_valid  in  1  strobe: lowest-priority pointer <= eoi_level; no ISR change.
- aeoi  in  1  automatic-EOI mode enable (static during operation).
- aeoi_rotate  in  1  rotate on automatic EOI.
- int_req  out  1  registered interrupt request to CPU.
- isr  out  N_IRQ  in-service register.
- vec_valid  out  1  one-cycle pulse after second INTA.
- vec_id  out  ID_W  acknowledged level, valid with vec_valid.
- spurious  out  1  qualifies vec_valid: no request existed at first INTA.

## Operation
- Lowest-priority pointer L, reset N_IRQ-1, so IR0 is highest priority. Rank of level i is (i - L - 1) mod N_IRQ; rank 0 is highest.
- Candidate: the lowest-rank bit of irr & ~imr.
- Nesting reference: the lowest-rank set bit of isr, or none if isr is empty.
- Request enable: a candidate exists and either isr is empty or the candidate rank < nesting-reference rank (fully nested).
- FSM states IDLE and ACK1:
  - IDLE + inta: isr[candidate] <= 1, latch candidate into vec_id, go to ACK1. If no candidate exists: set no ISR bit, latch vec_id = N_IRQ-1, set spurious flag.
  - ACK1 + inta: vec_valid = 1 for one cycle, then return to IDLE. If aeoi is set and the acknowledge was not spurious: clear isr[vec_id]; if aeoi_rotate, L <= vec_id.
  - inta in ACK1 is the only exit from ACK1; there is no timeout.
- EOI processing (any state):
  - Specific EOI: clear isr[eoi_level].
  - Non-specific EOI: clear the lowest-rank isr bit; no-op if isr is empty.
  - If eoi_rotate and a bit was cleared, L <= cleared level. A specific EOI with eoi_rotate on a clear bit still rotates.
- setprio_valid: L <= eoi_level. If asserted together with eoi_valid, setprio wins for L.
- Simultaneous events:
  - Rank evaluation in a cycle uses the L and isr values from before that cycle.
  - If the same isr bit is set by the first INTA and cleared by EOI in one cycle, the set wins.
- int_req is cleared on the first inta and in ACK1; it re-evaluates in IDLE.
- reset mid-sequence: FSM to IDLE, isr cleared, L = N_IRQ-1, all outputs 0.

## Timing
- Reset values: int_req 0, isr 0, vec_valid 0, vec_id 0, spurious 0.
- int_req asserts 1 cycle after request enable becomes true; it deasserts on the edge where inta is sampled.
- isr bit is visible 1 cycle after the first inta.
- vec_valid/vec_id/spurious are visible 1 cycle after the second inta. The AEOI clear is visible at the same edge.
- EOI or setprio effect is visible 1 cycle after the strobe.
- Candidate, rank and nesting logic are combinational from registered state and the irr/imr inputs.

## Configuration
- IRQ_ARB_AEOI_EN defined: automatic EOI as described above.
- IRQ_ARB_AEOI_EN not defined: aeoi and aeoi_rotate are ignored, and ISR bits clear only via eoi_valid. Ports remain present.

## Structure
- Package irq_arbiter_pkg holds:
  - FSM state enum (ST_IDLE, ST_ACK1).
  - Function rank(level, L, N).
- Sub-module rot_prio_enc (combinational): inputs a vector and L; outputs found flag and the lowest-rank index. It is instantiated twice, once for the candidate and once for the nesting reference.

## Test plan
- Reset, irr=8'h24, imr=0 -> int_req 1 cycle later; inta, inta -> isr=8'h04, vec_id=2, spurious=0.
- isr=8'h04 (IR2 in service), then irr IR1 raised -> int_req; irr IR5 only -> no int_req until non-specific EOI clears isr[2].
- Non-specific EOI with eoi_rotate after servicing IR3 -> L=3; irr=8'h11 -> next vec_id=4 (IR4 outranks IR0).
- irr pulse withdrawn before first inta -> vec_id=7, spurious=1, isr unchanged.
- With IRQ_ARB_AEOI_EN and aeoi=1: IR6 acknowledged -> isr[6] is 0 at the same edge vec_valid rises. Without the macro, isr[6] stays 1.
- Assert reset in ACK1 with isr=8'h81 -> isr=0, int_req=0, next single inta restarts from IDLE.
